// File: rtl/xram_arbiter.sv
// Two-master byte XRAM arbiter: grant in IDLE, one-cycle registered ack next cycle, one access per 2 cycles.
// Ties go to the accelerator unless XRAM_ARB_ROUND_ROBIN_EN is defined, which alternates by last grant.
module xram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_stb,
  input  logic             acc_wr,
  input  logic [15:0]      acc_addr,
  input  logic [7:0]       acc_wdata,
  output logic             acc_ack,
  output logic [7:0]       acc_rdata,
  input  logic             cpu_stb,
  input  logic             cpu_wr,
  input  logic [15:0]      cpu_addr,
  input  logic [7:0]       cpu_wdata,
  output logic             cpu_ack,
  output logic [7:0]       cpu_rdata,
  output logic [CNT_W-1:0] grant_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACK_A = 2'd1;
  localparam logic [1:0] ACK_C = 2'd2;

  logic [1:0]        r_state;
  logic              r_acc_ack;
  logic              r_cpu_ack;
  logic [7:0]        r_acc_rdata;
  logic [7:0]        r_cpu_rdata;
  logic [CNT_W-1:0]  r_grant_cnt;
  logic [7:0]        r_mem [2**ADDR_W];

  logic              w_idle;
  logic              w_acc_first;
  logic              w_gnt_a;
  logic              w_gnt_c;
  logic              w_wr;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_wdata;

`ifdef XRAM_ARB_ROUND_ROBIN_EN
  logic r_last_cpu;
  assign w_acc_first = r_last_cpu;
`else
  assign w_acc_first = 1'b1;
`endif

  assign w_idle  = (r_state == IDLE);
  assign w_gnt_a = w_idle & acc_stb & (~cpu_stb | w_acc_first);
  assign w_gnt_c = w_idle & cpu_stb & ~w_gnt_a;

  // Upper address bits are dropped so addresses alias onto the array.
  assign w_addr  = w_gnt_c ? cpu_addr[ADDR_W-1:0] : acc_addr[ADDR_W-1:0];
  assign w_wdata = w_gnt_c ? cpu_wdata : acc_wdata;
  assign w_wr    = w_gnt_c ? cpu_wr : acc_wr;
  assign w_we    = rst & (w_gnt_a | w_gnt_c) & w_wr;

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_addr] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_acc_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_acc_rdata <= 8'h00;
      r_cpu_rdata <= 8'h00;
      r_grant_cnt <= '0;
`ifdef XRAM_ARB_ROUND_ROBIN_EN
      r_last_cpu  <= 1'b1;
`endif
    end else begin
      r_acc_ack <= w_gnt_a;
      r_cpu_ack <= w_gnt_c;
      case (r_state)
        IDLE: begin
          if (w_gnt_a) begin
            r_state     <= ACK_A;
            r_grant_cnt <= r_grant_cnt + CNT_W'(1);
            if (!acc_wr) begin
              r_acc_rdata <= r_mem[w_addr];
            end
`ifdef XRAM_ARB_ROUND_ROBIN_EN
            r_last_cpu  <= 1'b0;
`endif
          end else if (w_gnt_c) begin
            r_state     <= ACK_C;
            r_grant_cnt <= r_grant_cnt + CNT_W'(1);
            if (!cpu_wr) begin
              r_cpu_rdata <= r_mem[w_addr];
            end
`ifdef XRAM_ARB_ROUND_ROBIN_EN
            r_last_cpu  <= 1'b1;
`endif
          end
        end
        ACK_A:   r_state <= IDLE;
        ACK_C:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign acc_ack   = r_acc_ack;
  assign cpu_ack   = r_cpu_ack;
  assign acc_rdata = r_acc_rdata;
  assign cpu_rdata = r_cpu_rdata;
  assign grant_cnt = r_grant_cnt;

endmodule

// File: tb/tb_xram_arbiter.sv
// Bench for xram_arbiter: directed vector table, burst/contention/reset sequences, random traffic vs a transaction model.
// Tie-break expectations follow XRAM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_xram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        acc_stb = 1'b0, acc_wr = 1'b0, cpu_stb = 1'b0, cpu_wr = 1'b0;
  logic [15:0] acc_addr = '0, cpu_addr = '0;
  logic [7:0]  acc_wdata = '0, cpu_wdata = '0;
  logic        acc_ack, cpu_ack;
  logic [7:0]  acc_rdata, cpu_rdata;
  logic [15:0] grant_cnt;

  always #5 clk = ~clk;

  xram_arbiter #(.ADDR_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .acc_stb(acc_stb), .acc_wr(acc_wr), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .acc_ack(acc_ack), .acc_rdata(acc_rdata),
    .cpu_stb(cpu_stb), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .grant_cnt(grant_cnt)
  );

  // Transaction-level reference: byte memory, per-port last read value, grant count, last winner.
  logic [7:0] mem_m [65536];
  logic [7:0] rd_a_m, rd_c_m;
  int         g_cnt;
  bit         last_cpu;
  int         n_cmp = 0;
  int         n_err = 0;

  typedef struct {
    bit          cpu;
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit acc_wins_tie();
`ifdef XRAM_ARB_ROUND_ROBIN_EN
    return last_cpu;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    g_cnt = 0; rd_a_m = 8'h00; rd_c_m = 8'h00; last_cpu = 1'b1;
  endtask

  task automatic model_grant(input bit cpu, input bit wr, input logic [15:0] addr, input logic [7:0] wdata);
    g_cnt++;
    last_cpu = cpu;
    if (wr) mem_m[addr] = wdata;
    else if (cpu) rd_c_m = mem_m[addr];
    else rd_a_m = mem_m[addr];
  endtask

  // Single isolated access from one port; starts and ends just after a rising edge.
  task automatic access(input bit cpu, input bit wr, input logic [15:0] addr, input logic [7:0] wdata,
                        input bit chk, input logic [7:0] exp);
    if (cpu) begin cpu_stb = 1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata; end
    else     begin acc_stb = 1; acc_wr = wr; acc_addr = addr; acc_wdata = wdata; end
    @(posedge clk); #1;
    cpu_stb = 0; acc_stb = 0;
    model_grant(cpu, wr, addr, wdata);
    check("ack_owner", cpu ? cpu_ack : acc_ack, 1);
    check("ack_other", cpu ? acc_ack : cpu_ack, 0);
    check("acc_rdata", acc_rdata, rd_a_m);
    check("cpu_rdata", cpu_rdata, rd_c_m);
    if (chk) check("vec_rdata", cpu ? cpu_rdata : acc_rdata, exp);
    @(posedge clk); #1;
    check("ack_drop", acc_ack | cpu_ack, 0);
    check("grant_cnt", grant_cnt, 16'(g_cnt));
  endtask

  task automatic do_reset();
    rst = 0; acc_stb = 0; cpu_stb = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_acc_ack", acc_ack, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_acc_rdata", acc_rdata, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_grant_cnt", grant_cnt, 0);
    rst = 1;
  endtask

  initial begin
    int idx;
    int k;
    bit ea, ec, exp_a, exp_c, prev_ack;

    vecs[0] = '{cpu: 1, wr: 1, addr: 16'h0100, wdata: 8'hA5, exp: 8'h00};
    vecs[1] = '{cpu: 1, wr: 0, addr: 16'h0100, wdata: 8'h00, exp: 8'hA5};
    vecs[2] = '{cpu: 0, wr: 1, addr: 16'h0300, wdata: 8'h3C, exp: 8'h00};
    vecs[3] = '{cpu: 1, wr: 0, addr: 16'h0300, wdata: 8'h00, exp: 8'h3C};
    vecs[4] = '{cpu: 0, wr: 0, addr: 16'h0100, wdata: 8'h00, exp: 8'hA5};
    vecs[5] = '{cpu: 1, wr: 0, addr: 16'h0300, wdata: 8'hFF, exp: 8'h3C};

    do_reset();

    access(vecs[0].cpu, vecs[0].wr, vecs[0].addr, vecs[0].wdata, 0, 0);
    access(vecs[1].cpu, vecs[1].wr, vecs[1].addr, vecs[1].wdata, 1, vecs[1].exp);
    check("cnt_after_two", grant_cnt, 2);
    for (int i = 2; i < 6; i++)
      access(vecs[i].cpu, vecs[i].wr, vecs[i].addr, vecs[i].wdata, !vecs[i].wr, vecs[i].exp);

    // Accelerator read burst with stb held continuously.
    for (int i = 0; i < 16; i++) access(1, 1, 16'h0200 + 16'(i), 8'(i), 0, 0);
    idx = 0;
    acc_stb = 1; acc_wr = 0; acc_addr = 16'h0200;
    for (int c = 0; c < 32; c++) begin
      @(posedge clk); #1;
      check("burst_ack", acc_ack, (c % 2 == 0) ? 1 : 0);
      if (acc_ack) begin
        check("burst_rdata", acc_rdata, idx);
        model_grant(0, 0, acc_addr, 0);
        idx++;
        acc_addr = 16'h0200 + 16'(idx);
      end
    end
    acc_stb = 0;
    check("burst_count", idx, 16);
    @(posedge clk); #1;

    // Contention: CPU reads 0x0010 while the accelerator streams writes.
    access(1, 1, 16'h0010, 8'h5A, 0, 0);
    k = 0;
    acc_stb = 1; acc_wr = 1; acc_addr = 16'h0500; acc_wdata = 8'h80;
    cpu_stb = 1; cpu_wr = 0; cpu_addr = 16'h0010;
`ifdef XRAM_ARB_ROUND_ROBIN_EN
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check("rr_acc_ack", acc_ack, (c % 4 == 0) ? 1 : 0);
      check("rr_cpu_ack", cpu_ack, (c % 4 == 2) ? 1 : 0);
      if (acc_ack) begin
        model_grant(0, 1, acc_addr, acc_wdata);
        k++; acc_addr = 16'h0500 + 16'(k); acc_wdata = 8'h80 + 8'(k);
      end
      if (cpu_ack) begin
        model_grant(1, 0, cpu_addr, 0);
        check("rr_cpu_rdata", cpu_rdata, 8'h5A);
      end
    end
    acc_stb = 0; cpu_stb = 0;
`else
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("fp_cpu_starved", cpu_ack, 0);
      check("fp_acc_ack", acc_ack, (c % 2 == 0) ? 1 : 0);
      if (acc_ack) begin
        model_grant(0, 1, acc_addr, acc_wdata);
        k++; acc_addr = 16'h0500 + 16'(k); acc_wdata = 8'h80 + 8'(k);
      end
    end
    acc_stb = 0;
    @(posedge clk); #1;
    cpu_stb = 0;
    check("fp_cpu_late_ack", cpu_ack, 1);
    model_grant(1, 0, 16'h0010, 0);
    check("fp_cpu_rdata", cpu_rdata, 8'h5A);
`endif
    @(posedge clk); #1;
    check("contention_cnt", grant_cnt, 16'(g_cnt));
    access(1, 0, 16'h0503, 0, 1, 8'h83);

    // Random traffic on a small hot region so read-after-write hazards occur often.
    for (int i = 0; i < 16; i++) access(0, 1, 16'h0600 + 16'(i), 8'($urandom), 0, 0);
    prev_ack = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      ea = acc_stb; ec = cpu_stb;
      @(posedge clk); #1;
      exp_a = 0; exp_c = 0;
      if (!prev_ack) begin
        if (ea && ec) begin
          exp_a = acc_wins_tie(); exp_c = !exp_a;
        end else begin
          exp_a = ea; exp_c = ec;
        end
      end
      prev_ack = exp_a | exp_c;
      if (acc_ack !== exp_a) check("rnd_acc_ack", acc_ack, exp_a);
      if (cpu_ack !== exp_c) check("rnd_cpu_ack", cpu_ack, exp_c);
      if (exp_a) model_grant(0, acc_wr, acc_addr, acc_wdata);
      if (exp_c) model_grant(1, cpu_wr, cpu_addr, cpu_wdata);
      if (exp_a | exp_c) begin
        check("rnd_acc_rdata", acc_rdata, rd_a_m);
        check("rnd_cpu_rdata", cpu_rdata, rd_c_m);
        check("rnd_grant_cnt", grant_cnt, 16'(g_cnt));
      end
      if (exp_a) acc_stb = 0;
      if (exp_c) cpu_stb = 0;
      if (!acc_stb && ($urandom_range(0, 1) == 1)) begin
        acc_stb = 1; acc_wr = 1'($urandom); acc_addr = 16'h0600 + 16'($urandom_range(0, 15));
        acc_wdata = 8'($urandom);
      end
      if (!cpu_stb && ($urandom_range(0, 2) == 0)) begin
        cpu_stb = 1; cpu_wr = 1'($urandom); cpu_addr = 16'h0600 + 16'($urandom_range(0, 15));
        cpu_wdata = 8'($urandom);
      end
    end
    acc_stb = 0; cpu_stb = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rnd_final_cnt", grant_cnt, 16'(g_cnt));

    // Reset during ACK_A of a committed write.
    acc_stb = 1; acc_wr = 1; acc_addr = 16'h0400; acc_wdata = 8'h77;
    @(posedge clk); #1;
    check("rst_ackA_high", acc_ack, 1);
    mem_m[16'h0400] = 8'h77;
    acc_stb = 0; rst = 0;
    @(posedge clk); #1;
    check("rst_ackA_cleared", acc_ack, 0);
    check("rst_ackA_cnt", grant_cnt, 0);
    model_reset();
    rst = 1;
    access(1, 0, 16'h0400, 0, 1, 8'h77);
    check("post_rst_cnt", grant_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
